// File: rtl/bpu_sched.sv
// Branch predictor table-port scheduler: lookups, resolved-update FIFO, table flush.
// Define BPU_SCHED_STARVE_EN to force FIFO drains after STARVE lookup-won cycles.
module bpu_sched #(
  parameter int IWIDTH = 6,
  parameter int QDEPTH = 4,
  parameter int STARVE = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              lk_valid,
  input  logic [IWIDTH-1:0] lk_index,
  output logic              lk_ready,
  input  logic              rs_valid,
  input  logic [IWIDTH-1:0] rs_index,
  input  logic              rs_taken,
  output logic              rs_ready,
  input  logic              flush_req,
  output logic              flush_busy,
  output logic [IWIDTH-1:0] tb_index,
  output logic              tb_re,
  output logic              tb_we,
  output logic              tb_wbit,
  output logic              tb_clr
);

  localparam int PW = $clog2(QDEPTH);

  if (QDEPTH < 2 || STARVE < 0) begin : g_bad_param
    $error("bpu_sched: bad QDEPTH/STARVE");
  end

  typedef enum logic {IDLE, FLUSH} state_t;

  state_t            state, state_nx;
  logic [IWIDTH:0]   mem [QDEPTH];
  logic [PW-1:0]     rptr, wptr;
  logic [PW:0]       count;
  logic [IWIDTH-1:0] walk;
  logic              empty, full;
  logic              push, pop;
  logic              forced, flush_go;

  assign empty = (count == '0);
  assign full  = (count == (PW+1)'(QDEPTH));
  assign push  = rs_valid && rs_ready && !flush_go;

`ifdef BPU_SCHED_STARVE_EN
  localparam int SW = $clog2(STARVE + 2);

  logic [SW-1:0] starve;

  assign forced = !empty && (starve == SW'(STARVE));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve <= '0;
    end else if (state != IDLE || pop || empty) begin
      starve <= '0;
    end else if (lk_ready && starve != SW'(STARVE)) begin
      starve <= starve + 1'b1;
    end
  end
`else
  assign forced = 1'b0;
`endif

  always_comb begin
    state_nx   = state;
    lk_ready   = 1'b0;
    rs_ready   = 1'b0;
    flush_busy = 1'b0;
    tb_index   = '0;
    tb_re      = 1'b0;
    tb_we      = 1'b0;
    tb_wbit    = 1'b0;
    tb_clr     = 1'b0;
    pop        = 1'b0;
    flush_go   = 1'b0;
    unique case (state)
      IDLE: begin
        rs_ready = !full;
        if (flush_req) begin
          flush_go = 1'b1;
          state_nx = FLUSH;
        end else if (lk_valid && !forced) begin
          lk_ready = 1'b1;
          tb_re    = 1'b1;
          tb_index = lk_index;
        end else if (!empty) begin
          pop                 = 1'b1;
          tb_we               = 1'b1;
          {tb_index, tb_wbit} = mem[rptr];
        end
      end
      FLUSH: begin
        flush_busy = 1'b1;
        tb_clr     = 1'b1;
        tb_index   = walk;
        if (walk == '1) state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      walk  <= '0;
    end else begin
      state <= state_nx;
      walk  <= (state == FLUSH) ? walk + 1'b1 : '0;
    end
  end

  // Entering FLUSH throws away any queued updates.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
    end else if (flush_go) begin
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      count <= count + (PW+1)'(push) - (PW+1)'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= {rs_index, rs_taken};
  end

endmodule

// File: tb/tb_bpu_sched.sv
// Scoreboard bench for bpu_sched: expected drains/clears queued by stimulus,
// popped and compared by a negedge monitor.
module tb_bpu_sched;

  logic       clk;
  logic       reset;
  logic       lk_valid;
  logic [5:0] lk_index;
  logic       lk_ready;
  logic       rs_valid;
  logic [5:0] rs_index;
  logic       rs_taken;
  logic       rs_ready;
  logic       flush_req;
  logic       flush_busy;
  logic [5:0] tb_index;
  logic       tb_re;
  logic       tb_we;
  logic       tb_wbit;
  logic       tb_clr;

  int errors = 0;
  int checks = 0;

  logic [6:0] q_drain [$];
  int         q_clr   [$];

  bpu_sched dut (
    .clk       (clk),
    .reset     (reset),
    .lk_valid  (lk_valid),
    .lk_index  (lk_index),
    .lk_ready  (lk_ready),
    .rs_valid  (rs_valid),
    .rs_index  (rs_index),
    .rs_taken  (rs_taken),
    .rs_ready  (rs_ready),
    .flush_req (flush_req),
    .flush_busy(flush_busy),
    .tb_index  (tb_index),
    .tb_re     (tb_re),
    .tb_we     (tb_we),
    .tb_wbit   (tb_wbit),
    .tb_clr    (tb_clr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_rs(input int idx, input logic tk, input bit exp_ok);
    rs_valid = 1'b1;
    rs_index = 6'(idx);
    rs_taken = tk;
    if (exp_ok) q_drain.push_back({6'(idx), tk});
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (tb_re || tb_we || tb_clr)
        chk("one_strobe", $countones({tb_re, tb_we, tb_clr}), 1);
      if (tb_we) begin
        if (q_drain.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL drain_unexpected: got idx=%0d bit=%0d required none",
                   tb_index, tb_wbit);
        end else begin
          chk("drain_entry", {tb_index, tb_wbit}, q_drain.pop_front());
        end
      end
      if (tb_clr) begin
        if (q_clr.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL clr_unexpected: got idx=%0d required none", tb_index);
        end else begin
          chk("clr_index", tb_index, q_clr.pop_front());
        end
      end
    end
  end

  initial begin
    reset     = 1'b1;
    lk_valid  = 1'b0;
    lk_index  = '0;
    rs_valid  = 1'b0;
    rs_index  = '0;
    rs_taken  = 1'b0;
    flush_req = 1'b0;
    #2;
    chk("rst_lk_ready", lk_ready, 0);
    chk("rst_rs_ready", rs_ready, 1);
    chk("rst_busy", flush_busy, 0);
    chk("rst_strobes", {tb_re, tb_we, tb_clr}, 0);
    chk("rst_index", tb_index, 0);
    chk("rst_wbit", tb_wbit, 0);
    lk_valid = 1'b1;
    lk_index = 6'd9;
    #1;
    chk("rst_lk_pass", lk_ready, 1);
    chk("rst_lk_re", tb_re, 1);
    chk("rst_lk_idx", tb_index, 9);
    lk_valid = 1'b0;
    lk_index = '0;
    step();
    reset = 1'b0;
    step();

    // single push, drained next cycle
    push_rs(5, 1'b1, 1);
    #1;
    chk("p1_rs_ready", rs_ready, 1);
    chk("p1_no_we", tb_we, 0);
    step();
    rs_valid = 1'b0;
    #1;
    chk("p1_we", tb_we, 1);
    chk("p1_idx", tb_index, 5);
    chk("p1_wbit", tb_wbit, 1);
    step();
    #1;
    chk("p1_empty", tb_we, 0);

    // fill while lookups block drains
    lk_valid = 1'b1;
    lk_index = 6'd7;
    for (int i = 1; i <= 4; i++) begin
      push_rs(i, 1'(i), 1);
      #1;
      chk("fill_rs_ready", rs_ready, 1);
      chk("fill_lk_win", lk_ready, 1);
      step();
    end
    push_rs(9, 1'b1, 0);
    #1;
    chk("full_rs_ready", rs_ready, 0);
    step();
    lk_valid = 1'b0;
    #1;
    chk("full_pop_rs_ready", rs_ready, 0);
    chk("full_pop_we", tb_we, 1);
    step();
    rs_valid = 1'b0;
    step();
    step();
    step();
    #1;
    chk("no_fifth", tb_we, 0);

    // push and pop together at count 2
    lk_valid = 1'b1;
    push_rs(10, 1'b1, 1);
    step();
    push_rs(11, 1'b0, 1);
    step();
    lk_valid = 1'b0;
    push_rs(12, 1'b1, 1);
    #1;
    chk("pp_rs_ready", rs_ready, 1);
    chk("pp_we", tb_we, 1);
    chk("pp_idx", tb_index, 10);
    step();
    rs_valid = 1'b0;
    #1;
    chk("pp_rs_ready2", rs_ready, 1);
    chk("pp_idx2", tb_index, 11);
    step();
    step();
    #1;
    chk("pp_empty", tb_we, 0);

    // flush with two queued entries
    lk_valid = 1'b1;
    lk_index = 6'd3;
    push_rs(20, 1'b1, 0);
    step();
    push_rs(21, 1'b0, 0);
    step();
    rs_valid  = 1'b0;
    flush_req = 1'b1;
    #1;
    chk("fl_go_lk", lk_ready, 0);
    chk("fl_go_strobes", {tb_re, tb_we, tb_clr}, 0);
    for (int i = 0; i < 64; i++) q_clr.push_back(i);
    step();
    flush_req = 1'b0;
    for (int i = 0; i < 64; i++) begin
      if (i == 5)  push_rs(33, 1'b1, 0);
      if (i == 6)  rs_valid = 1'b0;
      if (i == 30) flush_req = 1'b1;
      if (i == 31) flush_req = 1'b0;
      #1;
      chk("fl_busy", flush_busy, 1);
      chk("fl_clr", tb_clr, 1);
      chk("fl_lk_ready", lk_ready, 0);
      chk("fl_rs_ready", rs_ready, 0);
      step();
    end
    #1;
    chk("fl_done_busy", flush_busy, 0);
    chk("fl_done_lk", lk_ready, 1);
    chk("fl_clr_left", q_clr.size(), 0);
    lk_valid = 1'b0;
    #1;
    chk("fl_discard", tb_we, 0);
    step();

    // reset in the middle of a flush
    flush_req = 1'b1;
    for (int i = 0; i < 64; i++) q_clr.push_back(i);
    step();
    flush_req = 1'b0;
    for (int i = 0; i < 20; i++) step();
    chk("mid_walk", tb_index, 20);
    reset = 1'b1;
    #1;
    chk("mid_rst_busy", flush_busy, 0);
    chk("mid_rst_clr", tb_clr, 0);
    chk("mid_rst_rs", rs_ready, 1);
    q_clr.delete();
    step();
    reset = 1'b0;
    step();
    flush_req = 1'b1;
    for (int i = 0; i < 64; i++) q_clr.push_back(i);
    step();
    flush_req = 1'b0;
    #1;
    chk("restart_idx0", tb_index, 0);
    for (int i = 0; i < 64; i++) step();
    #1;
    chk("restart_done", flush_busy, 0);

    // lookup pressure against one queued update
    lk_valid = 1'b1;
    lk_index = 6'd4;
    push_rs(40, 1'b1, 1);
    step();
    rs_valid = 1'b0;
`ifdef BPU_SCHED_STARVE_EN
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("sv_lk_win", lk_ready, 1);
      chk("sv_no_we", tb_we, 0);
      step();
    end
    #1;
    chk("sv_forced_lk", lk_ready, 0);
    chk("sv_forced_we", tb_we, 1);
    step();
    #1;
    chk("sv_lk_back", lk_ready, 1);
`else
    for (int i = 0; i < 6; i++) begin
      #1;
      chk("ns_lk_win", lk_ready, 1);
      chk("ns_no_we", tb_we, 0);
      step();
    end
    lk_valid = 1'b0;
    #1;
    chk("ns_drain", tb_we, 1);
`endif
    step();
    lk_valid = 1'b0;
    step();
    step();
    chk("end_drain_left", q_drain.size(), 0);
    chk("end_clr_left", q_clr.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
